// File: rtl/lfsr_pkg.sv
// Shared constants and FSM state type for the LFSR stream statistics block.
package lfsr_pkg;
    localparam int unsigned LFSR_WIDTH = 16;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned DEF_WINDOW = 65535;
    localparam int unsigned HIST_BINS  = 8;
    localparam int unsigned HIST_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stats_state_e;
endpackage

// File: rtl/lfsr_stream_stats_if.sv
// Sample stream in, measurement results out; master = stream source, slave = stats block.
interface lfsr_stream_stats_if
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = LFSR_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic [WIDTH-1:0]      state_in;
    logic                  bit_in;
    logic                  bit_valid;
    logic                  clear;
    logic [HIST_SEL_W-1:0] hist_sel;
    logic [CNT_W-1:0]      ones_cnt;
    logic [CNT_W-1:0]      zeros_cnt;
    logic [CNT_W-1:0]      longest_one;
    logic [CNT_W-1:0]      longest_zero;
    logic [CNT_W-1:0]      period;
    logic                  done;
    logic                  timeout;
    logic [CNT_W-1:0]      hist_count;

    modport master (
        output state_in, bit_in, bit_valid, clear, hist_sel,
        input  ones_cnt, zeros_cnt, longest_one, longest_zero, period, done, timeout, hist_count
    );

    modport slave (
        input  state_in, bit_in, bit_valid, clear, hist_sel,
        output ones_cnt, zeros_cnt, longest_one, longest_zero, period, done, timeout, hist_count
    );
endinterface

// File: rtl/lfsr_run_tracker.sv
// Tracks the current bit run, the longest 1/0 runs, and flags each run as it closes.
module lfsr_run_tracker
    import lfsr_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic             step,
    input  logic             bit_in,
    output logic [CNT_W-1:0] longest_one,
    output logic [CNT_W-1:0] longest_zero,
    output logic             close_c,
    output logic [CNT_W-1:0] close_len_c
);
    logic             run_bit;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] len_d;

    // A closing run reports its final length in the same cycle the new run starts.
    always_comb begin
        close_c     = step && (bit_in != run_bit);
        close_len_c = run_len;
        len_d       = run_len;
        if (start || close_c) begin
            len_d = CNT_W'(1);
        end else if (step) begin
            len_d = (&run_len) ? run_len : run_len + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_bit      <= 1'b0;
            run_len      <= '0;
            longest_one  <= '0;
            longest_zero <= '0;
        end else if (clear) begin
            run_bit      <= 1'b0;
            run_len      <= '0;
            longest_one  <= '0;
            longest_zero <= '0;
        end else if (start || step) begin
            run_bit <= bit_in;
            run_len <= len_d;
            if (bit_in) begin
                longest_one <= (len_d > longest_one) ? len_d : longest_one;
            end else begin
                longest_zero <= (len_d > longest_zero) ? len_d : longest_zero;
            end
        end
    end
endmodule

// File: rtl/lfsr_stream_stats.sv
// Period / bit-balance / run-length statistics over one LFSR period or a bounded window.
// Optional run-length histogram enabled by defining LFSR_STATS_RUN_HIST_EN.
module lfsr_stream_stats
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH  = LFSR_WIDTH,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned WINDOW = DEF_WINDOW
) (
    input  logic                clk,
    input  logic                reset,
    lfsr_stream_stats_if.slave  bus
);
    stats_state_e     state_q;
    stats_state_e     state_d;
    logic             fire_c;
    logic             start_c;
    logic             match_c;
    logic             step_c;
    logic             win_hit_c;
    logic [WIDTH-1:0] ref_state;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] zeros_q;
    logic [CNT_W-1:0] period_q;
    logic             done_q;
    logic             timeout_q;
    logic [CNT_W-1:0] longest_one;
    logic [CNT_W-1:0] longest_zero;
    logic             close_c;
    logic [CNT_W-1:0] close_len_c;
    logic [CNT_W-1:0] hist_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.bit_valid) state_d = RUN;
                RUN:     if (match_c || win_hit_c) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Per-sample strobes; clear swallows a coincident sample.
    always_comb begin
        fire_c    = bus.bit_valid && !bus.clear;
        start_c   = 1'b0;
        match_c   = 1'b0;
        step_c    = 1'b0;
        win_hit_c = 1'b0;
        case (state_q)
            IDLE: start_c = fire_c;
            RUN: begin
                match_c   = fire_c && (bus.state_in == ref_state);
                step_c    = fire_c && (bus.state_in != ref_state);
                win_hit_c = step_c && (sample_cnt == CNT_W'(WINDOW - 1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_state  <= '0;
            sample_cnt <= '0;
            ones_q     <= '0;
            zeros_q    <= '0;
            period_q   <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (bus.clear) begin
            ref_state  <= '0;
            sample_cnt <= '0;
            ones_q     <= '0;
            zeros_q    <= '0;
            period_q   <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (start_c) begin
                ref_state <= bus.state_in;
            end
            if (start_c || step_c) begin
                sample_cnt <= sat_inc(sample_cnt);
                if (bus.bit_in) begin
                    ones_q <= sat_inc(ones_q);
                end else begin
                    zeros_q <= sat_inc(zeros_q);
                end
            end
            if (match_c) begin
                period_q <= sample_cnt;
                done_q   <= 1'b1;
            end
            if (win_hit_c) begin
                timeout_q <= 1'b1;
                done_q    <= 1'b1;
            end
        end
    end

    lfsr_run_tracker #(.CNT_W(CNT_W)) u_run (
        .clk          (clk),
        .rst_n        (reset),
        .clear        (bus.clear),
        .start        (start_c),
        .step         (step_c),
        .bit_in       (bus.bit_in),
        .longest_one  (longest_one),
        .longest_zero (longest_zero),
        .close_c      (close_c),
        .close_len_c  (close_len_c)
    );

`ifdef LFSR_STATS_RUN_HIST_EN
    logic [CNT_W-1:0]      bins [HIST_BINS];
    logic [HIST_SEL_W-1:0] bin_idx_c;

    // Runs of 8 or longer share the last bin.
    always_comb begin
        if (close_len_c >= CNT_W'(HIST_BINS)) begin
            bin_idx_c = HIST_SEL_W'(HIST_BINS - 1);
        end else begin
            bin_idx_c = HIST_SEL_W'(close_len_c - CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < HIST_BINS; i++) bins[i] <= '0;
            hist_q <= '0;
        end else if (bus.clear) begin
            for (int unsigned i = 0; i < HIST_BINS; i++) bins[i] <= '0;
            hist_q <= '0;
        end else begin
            hist_q <= bins[bus.hist_sel];
            if (close_c) begin
                bins[bin_idx_c] <= sat_inc(bins[bin_idx_c]);
            end
        end
    end
`else
    logic unused_hist;
    assign unused_hist = ^{bus.hist_sel, close_c, close_len_c};
    assign hist_q      = '0;
`endif

    assign bus.ones_cnt     = ones_q;
    assign bus.zeros_cnt    = zeros_q;
    assign bus.longest_one  = longest_one;
    assign bus.longest_zero = longest_zero;
    assign bus.period       = period_q;
    assign bus.done         = done_q;
    assign bus.timeout      = timeout_q;
    assign bus.hist_count   = hist_q;
endmodule

// File: tb/tb_lfsr_stream_stats.sv
// Bench for lfsr_stream_stats: two instances (long window / WINDOW=8) against a behavioural model.
module tb_lfsr_stream_stats;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    lfsr_stream_stats_if #(.WIDTH(16), .CNT_W(17)) bus_a ();
    lfsr_stream_stats_if #(.WIDTH(16), .CNT_W(16)) bus_b ();

    assign bus_b.state_in  = bus_a.state_in;
    assign bus_b.bit_in    = bus_a.bit_in;
    assign bus_b.bit_valid = bus_a.bit_valid;
    assign bus_b.clear     = bus_a.clear;
    assign bus_b.hist_sel  = bus_a.hist_sel;

    lfsr_stream_stats #(.WIDTH(16), .CNT_W(17), .WINDOW(70000)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    lfsr_stream_stats #(.WIDTH(16), .CNT_W(16), .WINDOW(8)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    // Reference model: index 0 = dut_a, 1 = dut_b. Phase 0 idle, 1 measuring, 2 finished.
    int m_st[2], m_ref[2], m_scnt[2], m_ones[2], m_zeros[2], m_lone[2], m_lzero[2];
    int m_period[2], m_done[2], m_to[2], m_rbit[2], m_rlen[2], m_hist[2];
    int m_bins[2][8];

    function automatic int sat1(int v, int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic model_clear(int k);
        m_st[k] = 0; m_ref[k] = 0; m_scnt[k] = 0; m_ones[k] = 0; m_zeros[k] = 0;
        m_lone[k] = 0; m_lzero[k] = 0; m_period[k] = 0; m_done[k] = 0; m_to[k] = 0;
        m_rbit[k] = 0; m_rlen[k] = 0; m_hist[k] = 0;
        for (int i = 0; i < 8; i++) m_bins[k][i] = 0;
    endtask

    task automatic model_count(int k, int b, int maxv, bit first);
        if (b != 0) m_ones[k] = sat1(m_ones[k], maxv);
        else        m_zeros[k] = sat1(m_zeros[k], maxv);
        m_scnt[k] = sat1(m_scnt[k], maxv);
        if (first) begin
            m_rbit[k] = b; m_rlen[k] = 1;
        end else if (b == m_rbit[k]) begin
            m_rlen[k] = sat1(m_rlen[k], maxv);
        end else begin
            int idx;
            idx = (m_rlen[k] > 8) ? 7 : m_rlen[k] - 1;
            m_bins[k][idx] = sat1(m_bins[k][idx], maxv);
            m_rbit[k] = b; m_rlen[k] = 1;
        end
        if (b != 0) m_lone[k]  = (m_rlen[k] > m_lone[k])  ? m_rlen[k] : m_lone[k];
        else        m_lzero[k] = (m_rlen[k] > m_lzero[k]) ? m_rlen[k] : m_lzero[k];
    endtask

    task automatic model_edge(int k, int window, int maxv);
        int s, b;
        s = int'(bus_a.state_in);
        b = int'(bus_a.bit_in);
        if (bus_a.clear) begin
            model_clear(k);
            return;
        end
        m_hist[k] = m_bins[k][bus_a.hist_sel];
        if (!bus_a.bit_valid || m_st[k] == 2) return;
        if (m_st[k] == 0) begin
            m_ref[k] = s; m_st[k] = 1;
            model_count(k, b, maxv, 1'b1);
        end else if (s == m_ref[k]) begin
            m_period[k] = m_scnt[k]; m_done[k] = 1; m_st[k] = 2;
        end else begin
            model_count(k, b, maxv, 1'b0);
            if (m_scnt[k] == window) begin
                m_to[k] = 1; m_done[k] = 1; m_st[k] = 2;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_clear(0);
            model_clear(1);
        end else begin
            model_edge(0, 70000, 131071);
            model_edge(1, 8, 65535);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input string tag, input int k,
                           input logic [31:0] ones, input logic [31:0] zeros,
                           input logic [31:0] lo, input logic [31:0] lz,
                           input logic [31:0] per, input logic dn, input logic to,
                           input logic [31:0] hc);
        int eh;
`ifdef LFSR_STATS_RUN_HIST_EN
        eh = m_hist[k];
`else
        eh = 0;
`endif
        chk({tag, ".ones_cnt"},     ones,  m_ones[k]);
        chk({tag, ".zeros_cnt"},    zeros, m_zeros[k]);
        chk({tag, ".longest_one"},  lo,    m_lone[k]);
        chk({tag, ".longest_zero"}, lz,    m_lzero[k]);
        chk({tag, ".period"},       per,   m_period[k]);
        chk({tag, ".done"},         32'(dn), m_done[k]);
        chk({tag, ".timeout"},      32'(to), m_to[k]);
        chk({tag, ".hist_count"},   hc,    eh);
    endtask

    // Every cycle, away from the active edge.
    always @(negedge clk) begin
        cmp_all("a", 0, 32'(bus_a.ones_cnt), 32'(bus_a.zeros_cnt), 32'(bus_a.longest_one),
                32'(bus_a.longest_zero), 32'(bus_a.period), bus_a.done, bus_a.timeout,
                32'(bus_a.hist_count));
        cmp_all("b", 1, 32'(bus_b.ones_cnt), 32'(bus_b.zeros_cnt), 32'(bus_b.longest_one),
                32'(bus_b.longest_zero), 32'(bus_b.period), bus_b.done, bus_b.timeout,
                32'(bus_b.hist_count));
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic drive(input logic v, input logic [15:0] s, input logic b, input logic c);
        bus_a.bit_valid = v;
        bus_a.state_in  = s;
        bus_a.bit_in    = b;
        bus_a.clear     = c;
        bus_a.hist_sel  = 3'($urandom_range(0, 7));
        @(posedge clk);
        #1;
    endtask

    task automatic read_hist(input logic [2:0] sel);
        bus_a.bit_valid = 1'b0;
        bus_a.clear     = 1'b0;
        bus_a.hist_sel  = sel;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] s;
    logic [15:0] seq4 [4];
    logic [9:0]  pat;

    initial begin
        bus_a.bit_valid = 1'b0;
        bus_a.state_in  = '0;
        bus_a.bit_in    = 1'b0;
        bus_a.clear     = 1'b0;
        bus_a.hist_sel  = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset.done", 32'(bus_a.done), 0);
        chk("reset.period", 32'(bus_a.period), 0);

        // Full maximal-length LFSR, one shift per cycle.
        s = 16'hACE1;
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, s, s[0], 1'b0);
            s = lfsr_next(s);
        end
        chk("lfsr.wrap", 32'(s), 32'h0000ACE1);
        bus_a.state_in = s;
        bus_a.bit_in   = s[0];
        @(negedge clk);
        chk("lfsr.done_early", 32'(bus_a.done), 0);
        @(posedge clk);
        #1;
        chk("lfsr.done", 32'(bus_a.done), 1);
        chk("lfsr.period", 32'(bus_a.period), 65535);
        chk("lfsr.ones", 32'(bus_a.ones_cnt), 32768);
        chk("lfsr.zeros", 32'(bus_a.zeros_cnt), 32767);
        chk("lfsr.timeout", 32'(bus_a.timeout), 0);
        for (int i = 0; i < 4; i++) drive(1'b1, 16'($urandom), 1'($urandom), 1'b0);
        chk("lfsr.held", 32'(bus_a.period), 65535);

        // Directed run pattern; dut_b also times out after 8 of these samples.
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        pat = 10'b0000100111;
        for (int i = 0; i < 10; i++) drive(1'b1, 16'(16'h1000 + i), pat[i], 1'b0);
        chk("dir.ones", 32'(bus_a.ones_cnt), 4);
        chk("dir.zeros", 32'(bus_a.zeros_cnt), 6);
        chk("dir.lone", 32'(bus_a.longest_one), 3);
        chk("dir.lzero", 32'(bus_a.longest_zero), 4);
        chk("win.done", 32'(bus_b.done), 1);
        chk("win.timeout", 32'(bus_b.timeout), 1);
        chk("win.period", 32'(bus_b.period), 0);
        chk("win.sum", 32'(bus_b.ones_cnt) + 32'(bus_b.zeros_cnt), 8);
`ifdef LFSR_STATS_RUN_HIST_EN
        read_hist(3'd0);
        chk("hist.bin0", 32'(bus_a.hist_count), 1);
        read_hist(3'd1);
        chk("hist.bin1", 32'(bus_a.hist_count), 1);
        read_hist(3'd2);
        chk("hist.bin2", 32'(bus_a.hist_count), 1);
        read_hist(3'd3);
        chk("hist.bin3", 32'(bus_a.hist_count), 0);
`else
        read_hist(3'd0);
        chk("hist.off", 32'(bus_a.hist_count), 0);
`endif

        // Four-state loop with valid on every other cycle.
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        seq4[0] = 16'h0011; seq4[1] = 16'h0022; seq4[2] = 16'h0033; seq4[3] = 16'h0044;
        for (int i = 0; i < 12; i++) drive(((i % 2) == 0), seq4[(i / 2) % 4], 1'($urandom), 1'b0);
        chk("gap.period_a", 32'(bus_a.period), 4);
        chk("gap.period_b", 32'(bus_b.period), 4);
        chk("gap.sum", 32'(bus_a.ones_cnt) + 32'(bus_a.zeros_cnt), 4);

        // Clear with a coincident sample mid-run.
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 16'(16'h0100 + i), 1'b1, 1'b0);
        drive(1'b1, 16'h0200, 1'b1, 1'b1);
        chk("clr.ones", 32'(bus_a.ones_cnt), 0);
        chk("clr.lone", 32'(bus_a.longest_one), 0);
        chk("clr.done", 32'(bus_a.done), 0);
        drive(1'b1, 16'h0300, 1'b0, 1'b0);
        drive(1'b1, 16'h0301, 1'b1, 1'b0);
        drive(1'b1, 16'h0302, 1'b1, 1'b0);
        drive(1'b1, 16'h0300, 1'b0, 1'b0);
        chk("clr.period", 32'(bus_a.period), 3);

        // Asynchronous reset mid-run.
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 16'(16'h0500 + i), 1'($urandom), 1'b0);
        chk("rst.pre_sum", 32'(bus_a.ones_cnt) + 32'(bus_a.zeros_cnt), 5);
        bus_a.bit_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst.ones_now", 32'(bus_a.ones_cnt), 0);
        chk("rst.zeros_now", 32'(bus_a.zeros_cnt), 0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 16'h0777, 1'b1, 1'b0);
        chk("rst.restart_ones", 32'(bus_a.ones_cnt), 1);
        drive(1'b1, 16'h0778, 1'b0, 1'b0);
        drive(1'b1, 16'h0777, 1'b0, 1'b0);
        chk("rst.restart_period", 32'(bus_a.period), 2);

        // Randomized stream over a small state set, sporadic clears.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 16'($urandom_range(0, 15)), 1'($urandom),
                  ($urandom_range(0, 39) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
